sid_reg_if: RTL and testbench
=============================

Name: sid_reg_if

Overview:
- Chip-side responder for the SID host register-write protocol.
- The host presents address, voice and data, then pulses a write strobe.
- This block samples the bus, detects the strobe rising edge and commits the byte into a per-voice register bank.
- It supplies a voice-indexed read port to the time-multiplexed voice engine, plus gate-edge pulses to the ADSR.

Parameters:
- NUM_VOICES, 3, number of voice register sets; voice indices >= NUM_VOICES are ignored.
- FREQ_LATCH, 1, 1: FREQ_LO is staged in a shadow register and commits to the freq output only when FREQ_HI is written; 0: each byte writes through immediately.

Ports:
- clk  in  1  system clock (5 MHz)
- rst_n  in  1  asynchronous active-low reset
- bus_addr  in  3  register address (ui_in[2:0])
- bus_voice  in  2  voice select (ui_in[4:3])
- bus_data  in  8  write data (uio_in)
- bus_we  in  1  write strobe, active high (ui_in[7]), asynchronous to clk
- rd_voice  in  2  read-port voice index (from slot counter)
- rd_freq  out  16  frequency word of rd_voice
- rd_pw  out  8  pulse width of rd_voice
- rd_atk  out  8  attack/decay byte of rd_voice
- rd_sus  out  8  sustain/release byte of rd_voice
- rd_wav  out  8  waveform/control byte of rd_voice (bit0 GATE, bit4 TRI, bit5 SAW, bit6 PULSE)
- gate_on  out  NUM_VOICES  one-cycle pulse, GATE 0->1 on that voice
- gate_off  out  NUM_VOICES  one-cycle pulse, GATE 1->0 on that voice
- wr_ack  out  1  one-cycle pulse on every accepted (committed) write

Behaviour:
- Address map:
  - 0 FREQ_LO, 1 FREQ_HI, 2 PW, 4 ATK, 5 SUS, 6 WAV.
  - 3 and 7 are reserved: not committed, no wr_ack.
- Capture stage (s1): every clk edge registers {bus_we, bus_addr, bus_voice, bus_data} together as one bundle.
- Sync stage (s2): registers we_s1 into we_s2.
- Commit condition: we_s1 & ~we_s2, evaluated with the s1 bundle.
  - Committed at the clk edge following the first edge that samples bus_we=1.
  - Strobe-to-register latency is therefore 2 edges.
- A strobe held high for N cycles commits exactly once. The next write needs at least one sampled low cycle.
- Commit is ignored when voice >= NUM_VOICES or the address is reserved. All state is unchanged and wr_ack stays 0.
- wr_ack is asserted for the cycle immediately after the commit edge (registered).
- FREQ_LATCH=1:
  - FREQ_LO writes lo_shadow[v] only; rd_freq is unchanged.
  - FREQ_HI writes freq[v] = {data, lo_shadow[v]}.
- FREQ_LATCH=0: LO and HI write freq[v][7:0] and freq[v][15:8] directly.
- WAV write:
  - Compare the new bit0 with the old bit0 of the same voice.
  - 0->1 pulses gate_on[v] for one cycle, coincident with wr_ack.
  - 1->0 pulses gate_off[v].
  - Rewriting the same gate value produces no pulse.
- Read port:
  - Purely combinational mux of the committed registers by rd_voice.
  - rd_voice >= NUM_VOICES returns all zeros.
  - A read of the voice being written shows the new value from the cycle after the commit edge.
- Reset (asynchronous, any time, including mid-strobe):
  - All registers, shadows, s1/s2 flops and pulse outputs go to 0.
  - All rd_* outputs read 0.
  - A strobe that is already high when rst_n deasserts produces a write. s2 is 0, so an edge is seen. This is intended.
- No back-pressure. A new strobe arriving before the previous commit is simply the next edge, and there is no queueing.

Test Plan:
- Reset, rd_voice=0..2 -> all rd_* = 0; gate_on/off and wr_ack remain 0 for 20 cycles.
- Voice 0: FREQ_LO=0x2C then FREQ_HI=0x11 (addr set 1 cycle before a 1-cycle strobe) ->
  - after LO, rd_freq = 0x0000;
  - 2 edges after the HI strobe, rd_freq = 0x112C;
  - wr_ack pulses exactly twice.
- Voice 1: PW=0x80, SUS=0x0F, WAV=0x41 -> rd_pw=0x80, rd_sus=0x0F, rd_wav=0x41 for rd_voice=1; gate_on[1] pulses once; voices 0 and 2 are unaffected.
- Voice 2: WAV=0x11, WAV=0x11, WAV=0x10 -> gate_on[2] once (first write), no pulse on the second, gate_off[2] once on the third.
- Strobe held 5 cycles with WAV=0x21 on voice 0; then a write with voice=3; then a write to addr 3 -> single commit and single wr_ack for the first; the other two leave the bank unchanged with no wr_ack.
- Assert rst_n low during a held strobe after FREQ_HI=0x19 is committed on voice 2, release while the strobe is low -> rd_freq of voice 2 = 0 and no wr_ack after release.

Source files
------------

// File: rtl/sid_reg_if_if.sv
// Host-side register-write bus of the SID responder: address, voice select,
// data byte and a write strobe that is asynchronous to the chip clock.
interface sid_reg_if_if;
    logic [2:0] bus_addr;
    logic [1:0] bus_voice;
    logic [7:0] bus_data;
    logic       bus_we;

    modport master (output bus_addr, output bus_voice, output bus_data, output bus_we);
    modport slave  (input  bus_addr, input  bus_voice, input  bus_data, input  bus_we);
endinterface

// File: rtl/sid_reg_if.sv
// SID register-write responder: samples the host bus, commits one byte per
// strobe rising edge into a per-voice bank, and serves a voice-indexed read port.
module sid_reg_if #(
    parameter int NUM_VOICES = 3,
    parameter bit FREQ_LATCH = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sid_reg_if_if.slave           bus,
    input  logic [1:0]            rd_voice,
    output logic [15:0]           rd_freq,
    output logic [7:0]            rd_pw,
    output logic [7:0]            rd_atk,
    output logic [7:0]            rd_sus,
    output logic [7:0]            rd_wav,
    output logic [NUM_VOICES-1:0] gate_on,
    output logic [NUM_VOICES-1:0] gate_off,
    output logic                  wr_ack
);
    localparam logic [2:0] ADDR_FREQ_LO = 3'd0;
    localparam logic [2:0] ADDR_FREQ_HI = 3'd1;
    localparam logic [2:0] ADDR_PW      = 3'd2;
    localparam logic [2:0] ADDR_ATK     = 3'd4;
    localparam logic [2:0] ADDR_SUS     = 3'd5;
    localparam logic [2:0] ADDR_WAV     = 3'd6;

    logic       we_s1_reg;
    logic       we_s2_reg;
    logic [2:0] addr_s1_reg;
    logic [1:0] voice_s1_reg;
    logic [7:0] data_s1_reg;
    logic       wr_ack_reg;

    // The whole bus is captured as one bundle so address/data always match the strobe sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_s1_reg    <= 1'b0;
            we_s2_reg    <= 1'b0;
            addr_s1_reg  <= 3'd0;
            voice_s1_reg <= 2'd0;
            data_s1_reg  <= 8'd0;
        end else begin
            we_s1_reg    <= bus.bus_we;
            we_s2_reg    <= we_s1_reg;
            addr_s1_reg  <= bus.bus_addr;
            voice_s1_reg <= bus.bus_voice;
            data_s1_reg  <= bus.bus_data;
        end
    end

    logic commit;
    logic addr_ok;
    logic voice_ok;
    logic accept;

    assign commit   = we_s1_reg & ~we_s2_reg;
    assign addr_ok  = (addr_s1_reg != 3'd3) && (addr_s1_reg != 3'd7);
    assign voice_ok = int'(voice_s1_reg) < NUM_VOICES;
    assign accept   = commit & addr_ok & voice_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_reg <= 1'b0;
        end else begin
            wr_ack_reg <= accept;
        end
    end

    assign wr_ack = wr_ack_reg;

    logic [15:0] freq_all [NUM_VOICES];
    logic [7:0]  pw_all   [NUM_VOICES];
    logic [7:0]  atk_all  [NUM_VOICES];
    logic [7:0]  sus_all  [NUM_VOICES];
    logic [7:0]  wav_all  [NUM_VOICES];

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic [15:0] freq_reg;
            logic [7:0]  lo_shadow_reg;
            logic [7:0]  pw_reg;
            logic [7:0]  atk_reg;
            logic [7:0]  sus_reg;
            logic [7:0]  wav_reg;
            logic        gate_on_reg;
            logic        gate_off_reg;
            logic        sel;

            assign sel = accept && (voice_s1_reg == 2'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    freq_reg      <= 16'd0;
                    lo_shadow_reg <= 8'd0;
                    pw_reg        <= 8'd0;
                    atk_reg       <= 8'd0;
                    sus_reg       <= 8'd0;
                    wav_reg       <= 8'd0;
                    gate_on_reg   <= 1'b0;
                    gate_off_reg  <= 1'b0;
                end else begin
                    gate_on_reg  <= 1'b0;
                    gate_off_reg <= 1'b0;
                    if (sel) begin
                        case (addr_s1_reg)
                            ADDR_FREQ_LO: begin
                                if (FREQ_LATCH) lo_shadow_reg  <= data_s1_reg;
                                else            freq_reg[7:0]  <= data_s1_reg;
                            end
                            ADDR_FREQ_HI: begin
                                if (FREQ_LATCH) freq_reg       <= {data_s1_reg, lo_shadow_reg};
                                else            freq_reg[15:8] <= data_s1_reg;
                            end
                            ADDR_PW:  pw_reg  <= data_s1_reg;
                            ADDR_ATK: atk_reg <= data_s1_reg;
                            ADDR_SUS: sus_reg <= data_s1_reg;
                            ADDR_WAV: begin
                                // Gate edges come from comparing against this voice's previous GATE bit.
                                wav_reg      <= data_s1_reg;
                                gate_on_reg  <= data_s1_reg[0] & ~wav_reg[0];
                                gate_off_reg <= ~data_s1_reg[0] & wav_reg[0];
                            end
                            default: ;
                        endcase
                    end
                end
            end

            assign freq_all[gi] = freq_reg;
            assign pw_all[gi]   = pw_reg;
            assign atk_all[gi]  = atk_reg;
            assign sus_all[gi]  = sus_reg;
            assign wav_all[gi]  = wav_reg;
            assign gate_on[gi]  = gate_on_reg;
            assign gate_off[gi] = gate_off_reg;
        end
    endgenerate

    // Out-of-range voice indices fall through to the all-zero default.
    always_comb begin
        rd_freq = 16'd0;
        rd_pw   = 8'd0;
        rd_atk  = 8'd0;
        rd_sus  = 8'd0;
        rd_wav  = 8'd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rd_voice == 2'(i)) begin
                rd_freq = freq_all[i];
                rd_pw   = pw_all[i];
                rd_atk  = atk_all[i];
                rd_sus  = sus_all[i];
                rd_wav  = wav_all[i];
            end
        end
    end
endmodule

// File: tb/tb_sid_reg_if.sv
// Scoreboard bench for sid_reg_if: writes push expected acks/pulses/readback,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_sid_reg_if;
    logic        clk;
    logic        rst_n;
    logic [1:0]  rd_voice;
    logic [15:0] rd_freq;
    logic [7:0]  rd_pw, rd_atk, rd_sus, rd_wav;
    logic [2:0]  gate_on, gate_off;
    logic        wr_ack;

    sid_reg_if_if bus_if ();

    sid_reg_if #(.NUM_VOICES(3), .FREQ_LATCH(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .rd_voice (rd_voice),
        .rd_freq  (rd_freq),
        .rd_pw    (rd_pw),
        .rd_atk   (rd_atk),
        .rd_sus   (rd_sus),
        .rd_wav   (rd_wav),
        .gate_on  (gate_on),
        .gate_off (gate_off),
        .wr_ack   (wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  gon;
        logic [2:0]  goff;
        logic [15:0] freq;
        logic [7:0]  pw;
        logic [7:0]  atk;
        logic [7:0]  sus;
        logic [7:0]  wav;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   ack_count = 0;
    int   pulse_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [2:0] gon, input logic [2:0] goff, input logic [15:0] freq,
                                input logic [7:0] pw, input logic [7:0] atk, input logic [7:0] sus,
                                input logic [7:0] wav);
        exp_t e;
        e.gon = gon; e.goff = goff; e.freq = freq;
        e.pw = pw; e.atk = atk; e.sus = sus; e.wav = wav;
        return e;
    endfunction

    // Monitor: every pulse cycle must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (wr_ack || (|gate_on) || (|gate_off)) begin
            exp_t e;
            pulse_cycles++;
            if (wr_ack) ack_count++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: got ack=%0b on=%b off=%b, expected none", wr_ack, gate_on, gate_off);
            end else begin
                e = exp_q.pop_front();
                $display("txn: voice=%0d ack=%0b on=%b off=%b freq=%h pw=%h atk=%h sus=%h wav=%h",
                         rd_voice, wr_ack, gate_on, gate_off, rd_freq, rd_pw, rd_atk, rd_sus, rd_wav);
                check("wr_ack",   32'(wr_ack),   32'd1);
                check("gate_on",  32'(gate_on),  32'(e.gon));
                check("gate_off", 32'(gate_off), 32'(e.goff));
                check("rd_freq",  32'(rd_freq),  32'(e.freq));
                check("rd_pw",    32'(rd_pw),    32'(e.pw));
                check("rd_atk",   32'(rd_atk),   32'(e.atk));
                check("rd_sus",   32'(rd_sus),   32'(e.sus));
                check("rd_wav",   32'(rd_wav),   32'(e.wav));
            end
        end
    end

    task automatic do_write(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d,
                            input int hold, input bit expect_ack, input exp_t e);
        @(posedge clk); #1;
        bus_if.bus_voice = v;
        bus_if.bus_addr  = a;
        bus_if.bus_data  = d;
        rd_voice = v;
        if (expect_ack) exp_q.push_back(e);
        @(posedge clk); #1;
        bus_if.bus_we = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus_if.bus_we = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic check_voice(input logic [1:0] v, input exp_t e);
        rd_voice = v;
        #1;
        $display("read: voice=%0d freq=%h pw=%h atk=%h sus=%h wav=%h", v, rd_freq, rd_pw, rd_atk, rd_sus, rd_wav);
        check($sformatf("v%0d_freq", v), 32'(rd_freq), 32'(e.freq));
        check($sformatf("v%0d_pw", v),   32'(rd_pw),   32'(e.pw));
        check($sformatf("v%0d_atk", v),  32'(rd_atk),  32'(e.atk));
        check($sformatf("v%0d_sus", v),  32'(rd_sus),  32'(e.sus));
        check($sformatf("v%0d_wav", v),  32'(rd_wav),  32'(e.wav));
    endtask

    initial begin
        exp_t z;
        z = mk(3'b000, 3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b0;
        rd_voice = 2'd0;
        bus_if.bus_we = 1'b0;
        bus_if.bus_addr = 3'd0;
        bus_if.bus_voice = 2'd0;
        bus_if.bus_data = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        for (int v = 0; v < 3; v++) check_voice(2'(v), z);
        repeat (20) @(posedge clk);
        check("idle_pulses", 32'(pulse_cycles), 32'd0);

        // Voice 0 latched frequency
        do_write(2'd0, 3'd0, 8'h2C, 1, 1'b1, mk(3'b000, 3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00));
        do_write(2'd0, 3'd1, 8'h11, 1, 1'b1, mk(3'b000, 3'b000, 16'h112C, 8'h00, 8'h00, 8'h00, 8'h00));
        check("ack_count_v0", 32'(ack_count), 32'd2);

        // Voice 1 PW/SUS/WAV with gate on
        do_write(2'd1, 3'd2, 8'h80, 1, 1'b1, mk(3'b000, 3'b000, 16'h0000, 8'h80, 8'h00, 8'h00, 8'h00));
        do_write(2'd1, 3'd5, 8'h0F, 1, 1'b1, mk(3'b000, 3'b000, 16'h0000, 8'h80, 8'h00, 8'h0F, 8'h00));
        do_write(2'd1, 3'd6, 8'h41, 1, 1'b1, mk(3'b010, 3'b000, 16'h0000, 8'h80, 8'h00, 8'h0F, 8'h41));
        check_voice(2'd0, mk(3'b000, 3'b000, 16'h112C, 8'h00, 8'h00, 8'h00, 8'h00));
        check_voice(2'd2, z);
        check("ack_count_v1", 32'(ack_count), 32'd5);

        // Voice 2 gate edges
        do_write(2'd2, 3'd6, 8'h11, 1, 1'b1, mk(3'b100, 3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h11));
        do_write(2'd2, 3'd6, 8'h11, 1, 1'b1, mk(3'b000, 3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h11));
        do_write(2'd2, 3'd6, 8'h10, 1, 1'b1, mk(3'b000, 3'b100, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h10));
        check("ack_count_v2", 32'(ack_count), 32'd8);

        // Voice 0 attack, then a strobe held 5 cycles
        do_write(2'd0, 3'd4, 8'hA5, 1, 1'b1, mk(3'b000, 3'b000, 16'h112C, 8'h00, 8'hA5, 8'h00, 8'h00));
        do_write(2'd0, 3'd6, 8'h21, 5, 1'b1, mk(3'b001, 3'b000, 16'h112C, 8'h00, 8'hA5, 8'h00, 8'h21));
        check("ack_count_held", 32'(ack_count), 32'd10);

        // Ignored writes: voice 3 and reserved address 3
        do_write(2'd3, 3'd6, 8'h01, 1, 1'b0, z);
        check_voice(2'd3, z);
        do_write(2'd0, 3'd3, 8'h55, 1, 1'b0, z);
        check("ack_count_ignored", 32'(ack_count), 32'd10);
        check_voice(2'd0, mk(3'b000, 3'b000, 16'h112C, 8'h00, 8'hA5, 8'h00, 8'h21));
        check_voice(2'd1, mk(3'b000, 3'b000, 16'h0000, 8'h80, 8'h00, 8'h0F, 8'h41));
        check_voice(2'd2, mk(3'b000, 3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h10));

        // Reset asserted mid-strobe after FREQ_HI commits on voice 2
        @(posedge clk); #1;
        bus_if.bus_voice = 2'd2;
        bus_if.bus_addr  = 3'd1;
        bus_if.bus_data  = 8'h19;
        rd_voice = 2'd2;
        exp_q.push_back(mk(3'b000, 3'b000, 16'h1900, 8'h00, 8'h00, 8'h00, 8'h10));
        @(posedge clk); #1;
        bus_if.bus_we = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus_if.bus_we = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("ack_count_reset", 32'(ack_count), 32'd11);
        for (int v = 0; v < 3; v++) check_voice(2'(v), z);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
